ifetch_unit: RTL

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_if.sv | 24 ++
 rtl/ifetch_unit.sv | 72 +++++++
 2 files changed

// File: rtl/ifetch_if.sv
// ifetch_if: fetch-side memory, redirect and instruction-queue output signals of ifetch_unit
interface ifetch_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   logic                           mem_ce;
   logic [XLEN-1:0]                mem_addr;
   logic [31:0]                    mem_inst;
   logic                           redirect;
   logic [XLEN-1:0]                redirect_pc;
   logic                           out_valid;
   logic                           out_ready;
   logic [31:0]                    out_inst;
   logic [XLEN-1:0]                out_pc;
   logic [$clog2(DEPTH+1)-1:0]     count;
   modport slave (
      output mem_ce, mem_addr, out_valid, out_inst, out_pc, count,
      input  mem_inst, redirect, redirect_pc, out_ready
   );
   modport master (
      input  mem_ce, mem_addr, out_valid, out_inst, out_pc, count,
      output mem_inst, redirect, redirect_pc, out_ready
   );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: sequential PC fetch into a circular prefetch queue with redirect support.
// Define IFETCH_BYPASS_EN to present a fetch on the output in the same cycle when the queue is empty.
module ifetch_unit #(
   parameter int XLEN     = 32,
   parameter int DEPTH    = 4,
   parameter int RESET_PC = 0,
   parameter int PC_STEP  = 4
) (
   input  logic     clk,
   input  logic     rst,
   ifetch_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] r_pc;
   logic [AW-1:0]   r_head, r_tail;
   logic [CW-1:0]   r_count;
   logic [XLEN-1:0] r_pc_q   [DEPTH];
   logic [31:0]     r_inst_q [DEPTH];
   logic            w_nempty, w_pop, w_ce, w_push, w_byp;

   // Queue pop is computed from stored entries only, so mem_ce never depends on itself.
   assign w_nempty = (r_count != '0) && !bus.redirect && !rst;
   assign w_pop    = w_nempty && bus.out_ready;
   assign w_ce     = !rst && !bus.redirect && ((r_count < CW'(DEPTH)) || w_pop);

`ifdef IFETCH_BYPASS_EN
   assign w_byp         = (r_count == '0);
   assign bus.out_valid = w_nempty || w_ce;
   assign w_push        = w_ce && !(w_byp && bus.out_ready);
`else
   assign w_byp         = 1'b0;
   assign bus.out_valid = w_nempty;
   assign w_push        = w_ce;
`endif

   assign bus.mem_ce   = w_ce;
   assign bus.mem_addr = r_pc;
   assign bus.count    = r_count;
   assign bus.out_inst = w_byp ? bus.mem_inst : r_inst_q[r_head];
   assign bus.out_pc   = w_byp ? r_pc : r_pc_q[r_head];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc    <= XLEN'(RESET_PC);
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (bus.redirect) begin
         r_pc    <= bus.redirect_pc;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_ce)
            r_pc <= r_pc + XLEN'(PC_STEP);
         if (w_push)
            r_tail <= r_tail + 1'b1;
         if (w_pop)
            r_head <= r_head + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_q[r_tail]   <= r_pc;
         r_inst_q[r_tail] <= bus.mem_inst;
      end
   end
endmodule
